// File: rtl/result_packer.sv
// Packs PACK consecutive core results into one wide word with frame-boundary marking,
// queued in a 2-entry output FIFO. Optional flush port enabled by RESULT_PACKER_FLUSH_EN.
module result_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK       = 4,
  parameter int FRAME_LEN  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
`ifdef RESULT_PACKER_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_last
);

  localparam int LW = $clog2(PACK);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] LANE_LAST  = LW'(PACK - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  logic [LW-1:0]              lane_cnt;
  logic [FW-1:0]              frame_cnt;
  logic [PACK*DATA_WIDTH-1:0] pack_reg;

  logic [PACK*DATA_WIDTH-1:0] fifo_data [2];
  logic [PACK-1:0]            fifo_keep [2];
  logic                       fifo_last [2];
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 fifo_cnt;

  logic                       accept;
  logic                       pop;
  logic                       push;
  logic                       frame_end;
  logic                       complete;
  logic                       flush_fire;
  logic [PACK*DATA_WIDTH-1:0] word_data;
  logic [PACK-1:0]            word_keep;
  logic                       word_last;

  // Ready depends only on registered FIFO occupancy, never on out_ready.
  assign in_ready  = (fifo_cnt != 2'd2);
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_keep  = fifo_keep[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign frame_end = (frame_cnt == FRAME_LAST);
  assign complete  = accept && ((lane_cnt == LANE_LAST) || frame_end);

`ifdef RESULT_PACKER_FLUSH_EN
  assign flush_fire = flush && in_ready;
`else
  assign flush_fire = 1'b0;
`endif

  // A flush closes whatever is buffered, plus the sample arriving on the same edge.
  assign push      = complete || (flush_fire && ((lane_cnt != '0) || accept));
  assign word_last = (accept && frame_end) || flush_fire;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    word_data = '0;
    word_keep = '0;
    for (int k = 0; k < PACK; k++) begin
      if (LW'(k) < lane_cnt) begin
        word_data[k*DATA_WIDTH +: DATA_WIDTH] = pack_reg[k*DATA_WIDTH +: DATA_WIDTH];
        word_keep[k] = 1'b1;
      end else if ((LW'(k) == lane_cnt) && accept) begin
        word_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        word_keep[k] = 1'b1;
      end
    end
  end

  // Lane/frame bookkeeping; stale lanes in pack_reg are masked when the word is built.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      lane_cnt  <= '0;
      frame_cnt <= '0;
      pack_reg  <= '0;
    end else begin
      if (accept) begin
        pack_reg[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= in_data;
      end
      if (flush_fire) begin
        lane_cnt  <= '0;
        frame_cnt <= '0;
      end else if (accept) begin
        lane_cnt  <= complete  ? '0 : lane_cnt + 1'b1;
        frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the two FIFO entries are reset so out_data/out_keep/out_last read zero straight out of reset.
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_keep[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= word_data;
        fifo_keep[wr_ptr] <= word_keep;
        fifo_last[wr_ptr] <= word_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
